factorial_seq_param: RTL and testbench

- Parametrised sequential factorial engine, the next generation of the team's fixed 8-bit/16-bit factorial unit.
- Computes n! (mode 0) or the double factorial n!! (mode 1) with one multiply per clock, using a start/ready/done handshake.
- Overflow handling is selectable at build time: flag an error, or saturate.
- Result is held stable after completion for downstream sampling; an in-flight computation can be aborted.

---
 rtl/factorial_seq_param.sv | 103 ++++++++++
 tb/tb_factorial_seq_param.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/factorial_seq_param.sv
// Sequential n! / n!! engine with one multiply per clock and a start/ready/done handshake.
// Latency: done pulses M+2 cycles after start is accepted (M = multiplies); ready again at M+3.
// Backpressure: start is taken only in IDLE; abort cancels an OP run; overflow errors or saturates.
module factorial_seq_param #(
  parameter int N_W      = 8,
  parameter int OUT_W    = 32,
  parameter int SAT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             abort,
  input  logic [N_W-1:0]   n,
  output logic [OUT_W-1:0] out,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             sat
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OP    = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  logic [1:0]           state;
  logic [OUT_W-1:0]     acc;
  logic [N_W-1:0]       cnt;
  logic [1:0]           step;
  logic                 sat_flag;

  logic [OUT_W+N_W-1:0] prod;
  logic                 ovf;
  logic [N_W:0]         cnt_dec;
  logic                 cnt_le1;

  // Full-width product so the upper N_W bits expose any overflow of the accumulator.
  always_comb begin
    prod    = {{N_W{1'b0}}, acc} * {{OUT_W{1'b0}}, cnt};
    ovf     = |prod[OUT_W+N_W-1:OUT_W];
    // One extra bit keeps the subtraction legal even when N_W is 1.
    cnt_dec = {1'b0, cnt} - (N_W+1)'(step);
    cnt_le1 = (cnt <= N_W'(1));
  end

  // State, accumulator, countdown and saturation latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      cnt      <= '0;
      step     <= 2'd1;
      sat_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          sat_flag <= 1'b0;
          if (start) begin
            acc   <= OUT_W'(1);
            cnt   <= n;
            step  <= mode ? 2'd2 : 2'd1;
            state <= S_OP;
          end
        end
        S_OP: begin
          if (abort) begin
            // Partial product is left visible on out.
            state <= S_IDLE;
          end else if (cnt_le1) begin
            state <= S_DONE;
          end else if (ovf) begin
            if (SAT_MODE != 0) begin
              acc      <= '1;
              sat_flag <= 1'b1;
              state    <= S_DONE;
            end else begin
              // Keep the last partial product that still fit.
              state <= S_ERROR;
            end
          end else begin
            acc <= prod[OUT_W-1:0];
            cnt <= cnt_dec[N_W-1:0];
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    out   = acc;
    ready = (state == S_IDLE);
    busy  = (state == S_OP);
    done  = (state == S_DONE) || (state == S_ERROR);
    error = (state == S_ERROR);
    sat   = (state == S_DONE) && sat_flag;
  end

endmodule

// File: tb/tb_factorial_seq_param.sv
module tb_factorial_seq_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic        abort;
  logic [7:0]  n;

  logic [31:0] out0, out1;
  logic        ready0, busy0, done0, error0, sat0;
  logic        ready1, busy1, done1, error1, sat1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  factorial_seq_param #(.N_W(8), .OUT_W(32), .SAT_MODE(0)) dut_err (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort), .n(n),
    .out(out0), .ready(ready0), .busy(busy0), .done(done0), .error(error0), .sat(sat0)
  );

  factorial_seq_param #(.N_W(8), .OUT_W(32), .SAT_MODE(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort), .n(n),
    .out(out1), .ready(ready1), .busy(busy1), .done(done1), .error(error1), .sat(sat1)
  );

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run in the current cycle (cycle 0) and follow it until dut_err pulses done.
  task automatic run(input logic m, input logic [7:0] nv, input bit hold,
                     output int dcyc, output int bcnt, output int nstart_busy,
                     output logic [31:0] o0, output logic e0, output logic s0,
                     output logic [31:0] o1, output logic e1, output logic s1,
                     output logic rdy_after);
    int cyc;
    start = 1'b1; mode = m; n = nv;
    cyc = 0; dcyc = -1; bcnt = 0; nstart_busy = -1;
    o0 = 'x; e0 = 1'bx; s0 = 1'bx; o1 = 'x; e1 = 1'bx; s1 = 1'bx;
    while (dcyc < 0 && cyc < 400) begin
      tick();
      cyc++;
      if (!hold) start = 1'b0;
      if (busy0) begin
        bcnt++;
        if (nstart_busy < 0) nstart_busy = cyc;
      end
      if (done0) begin
        dcyc = cyc;
        o0 = out0; e0 = error0; s0 = sat0;
        o1 = out1; e1 = error1; s1 = sat1;
      end
    end
    start = 1'b0;
    tick();
    rdy_after = ready0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; n = '0;
    tick(); tick();
    rst = 1'b0;
    tests++; if (out0 !== 32'd0) begin fails++; $display("FAIL reset_out got=%0d exp=0", out0); end
    tests++; if ({ready0, busy0, done0, error0, sat0} !== 5'b10000) begin
      fails++; $display("FAIL reset_flags got=%b exp=10000", {ready0, busy0, done0, error0, sat0});
    end
  endtask

  task automatic test_fact5();
    int dc, bc, fb; logic [31:0] o0, o1; logic e0, s0, e1, s1, ra;
    run(1'b0, 8'd5, 1'b0, dc, bc, fb, o0, e0, s0, o1, e1, s1, ra);
    tests++; if (dc !== 6) begin fails++; $display("FAIL f5_done_cycle got=%0d exp=6", dc); end
    tests++; if (o0 !== 32'd120) begin fails++; $display("FAIL f5_out got=%0d exp=120", o0); end
    tests++; if (e0 !== 1'b0) begin fails++; $display("FAIL f5_error got=%b exp=0", e0); end
    tests++; if (bc !== 5 || fb !== 1) begin fails++; $display("FAIL f5_busy got=%0d@%0d exp=5@1", bc, fb); end
    tests++; if (ra !== 1'b1) begin fails++; $display("FAIL f5_ready got=%b exp=1", ra); end
    tick(); tick(); tick();
    tests++; if (out0 !== 32'd120 || done0 !== 1'b0) begin
      fails++; $display("FAIL f5_hold got=%0d/%b exp=120/0", out0, done0);
    end
  endtask

  task automatic test_small_and_double();
    int dc, bc, fb; logic [31:0] o0, o1; logic e0, s0, e1, s1, ra;
    logic [7:0]  nv  [4] = '{8'd0, 8'd1, 8'd7, 8'd8};
    logic        mv  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] ev  [4] = '{32'd1, 32'd1, 32'd105, 32'd384};
    int          dv  [4] = '{2, 2, 5, 6};
    for (int i = 0; i < 4; i++) begin
      run(mv[i], nv[i], 1'b0, dc, bc, fb, o0, e0, s0, o1, e1, s1, ra);
      tests++; if (o0 !== ev[i] || dc !== dv[i]) begin
        fails++; $display("FAIL vec%0d_m%0d_n%0d got=%0d@%0d exp=%0d@%0d", i, mv[i], nv[i], o0, dc, ev[i], dv[i]);
      end
    end
    // n=1 in double-factorial mode also takes no multiplies.
    run(1'b1, 8'd1, 1'b0, dc, bc, fb, o0, e0, s0, o1, e1, s1, ra);
    tests++; if (o0 !== 32'd1 || dc !== 2) begin fails++; $display("FAIL dbl_n1 got=%0d@%0d exp=1@2", o0, dc); end
  endtask

  task automatic test_overflow();
    int dc, bc, fb; logic [31:0] o0, o1; logic e0, s0, e1, s1, ra;
    run(1'b0, 8'd13, 1'b0, dc, bc, fb, o0, e0, s0, o1, e1, s1, ra);
    tests++; if (dc !== 13 || e0 !== 1'b1) begin fails++; $display("FAIL ovf_err got=%0d/%b exp=13/1", dc, e0); end
    tests++; if (o0 !== 32'd3113510400) begin fails++; $display("FAIL ovf_out got=%0d exp=3113510400", o0); end
    tests++; if (o1 !== 32'hFFFF_FFFF || s1 !== 1'b1 || e1 !== 1'b0) begin
      fails++; $display("FAIL sat13 got=%h/%b/%b exp=ffffffff/1/0", o1, s1, e1);
    end
    tests++; if (s0 !== 1'b0) begin fails++; $display("FAIL ovf_no_sat got=%b exp=0", s0); end
    run(1'b0, 8'd12, 1'b0, dc, bc, fb, o0, e0, s0, o1, e1, s1, ra);
    tests++; if (o0 !== 32'd479001600 || e0 !== 1'b0 || dc !== 13) begin
      fails++; $display("FAIL f12 got=%0d/%b@%0d exp=479001600/0@13", o0, e0, dc);
    end
    run(1'b0, 8'd4, 1'b0, dc, bc, fb, o0, e0, s0, o1, e1, s1, ra);
    tests++; if (o1 !== 32'd24 || s1 !== 1'b0) begin fails++; $display("FAIL sat_f4 got=%0d/%b exp=24/0", o1, s1); end
  endtask

  task automatic test_max_n();
    int dc, bc, fb; logic [31:0] o0, o1; logic e0, s0, e1, s1, ra;
    // 255*253*251*249 fits in 32 bits; the next multiply by 247 does not.
    run(1'b1, 8'd255, 1'b0, dc, bc, fb, o0, e0, s0, o1, e1, s1, ra);
    tests++; if (o0 !== 32'd4032122985 || e0 !== 1'b1 || dc !== 6) begin
      fails++; $display("FAIL max_err got=%0d/%b@%0d exp=4032122985/1@6", o0, e0, dc);
    end
    tests++; if (o1 !== 32'hFFFF_FFFF || s1 !== 1'b1) begin fails++; $display("FAIL max_sat got=%h/%b exp=ffffffff/1", o1, s1); end
  endtask

  task automatic test_abort();
    int dpulses = 0;
    start = 1'b1; mode = 1'b0; n = 8'd6;
    tick(); start = 1'b0;           // cycle 1
    tick();                          // cycle 2
    tick(); abort = 1'b1;           // cycle 3
    tick(); abort = 1'b0;           // cycle 4
    tests++; if (ready0 !== 1'b1 || out0 !== 32'd30) begin
      fails++; $display("FAIL abort_state got=%b/%0d exp=1/30", ready0, out0);
    end
    for (int i = 0; i < 8; i++) begin
      if (done0) dpulses++;
      tick();
    end
    tests++; if (dpulses !== 0 || out0 !== 32'd30) begin
      fails++; $display("FAIL abort_nodone got=%0d/%0d exp=0/30", dpulses, out0);
    end
  endtask

  task automatic test_start_held();
    int dc, bc, fb; logic [31:0] o0, o1; logic e0, s0, e1, s1, ra;
    run(1'b0, 8'd5, 1'b1, dc, bc, fb, o0, e0, s0, o1, e1, s1, ra);
    tests++; if (dc !== 6 || bc !== 5 || o0 !== 32'd120) begin
      fails++; $display("FAIL held_start got=%0d@%0d busy=%0d exp=120@6 busy=5", o0, dc, bc);
    end
  endtask

  task automatic test_back_to_back();
    int dc, bc, fb; logic [31:0] o0, o1; logic e0, s0, e1, s1, ra;
    run(1'b0, 8'd3, 1'b0, dc, bc, fb, o0, e0, s0, o1, e1, s1, ra);
    run(1'b0, 8'd4, 1'b0, dc, bc, fb, o0, e0, s0, o1, e1, s1, ra);
    tests++; if (o0 !== 32'd24 || dc !== 5) begin fails++; $display("FAIL b2b got=%0d@%0d exp=24@5", o0, dc); end
  endtask

  task automatic test_mid_reset();
    int dc, bc, fb; logic [31:0] o0, o1; logic e0, s0, e1, s1, ra;
    start = 1'b1; mode = 1'b0; n = 8'd9;
    tick(); start = 1'b0;           // cycle 1
    tick(); rst = 1'b1;             // cycle 2
    tick(); rst = 1'b0;             // cycle 3
    tests++; if (out0 !== 32'd0 || ready0 !== 1'b1 || done0 !== 1'b0 || busy0 !== 1'b0) begin
      fails++; $display("FAIL midrst got=%0d r=%b d=%b b=%b exp=0 r=1 d=0 b=0", out0, ready0, done0, busy0);
    end
    run(1'b0, 8'd3, 1'b0, dc, bc, fb, o0, e0, s0, o1, e1, s1, ra);
    tests++; if (o0 !== 32'd6 || dc !== 4) begin fails++; $display("FAIL midrst_rerun got=%0d@%0d exp=6@4", o0, dc); end
  endtask

  initial begin
    test_reset();
    test_fact5();
    test_small_and_double();
    test_overflow();
    test_max_n();
    test_abort();
    test_start_held();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
